// File: rtl/aes_block_serializer_pkg.sv
// Shared AES package: block/word geometry, serializer state encoding and
// the serializer progress-flag bundle. Also used by the AES engine.
package aes_package;

  localparam int unsigned AES_BLOCK_WIDTH     = 128;
  localparam int unsigned AES_WORD_WIDTH      = 32;
  localparam int unsigned AES_WORDS_PER_BLOCK = 4;

  localparam int unsigned AES_SER_IDX_WIDTH = $clog2(AES_WORDS_PER_BLOCK);
  localparam int unsigned AES_SER_CNT_WIDTH = 16;

  typedef enum logic [0:0] {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } aes_ser_state_e;

  typedef struct packed {
    logic                         busy;
    logic [AES_SER_IDX_WIDTH-1:0] word_idx;
    logic [AES_SER_CNT_WIDTH-1:0] blocks_done;
  } flags_serializer_t;

endpackage

// File: rtl/aes_block_serializer_if.sv
// HWPE stream interface: data/valid/ready/strb word channel.
// source/master drive data, sink/slave provide ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input  ready);
  modport sink   (input  valid, input  data, input  strb, output ready);
  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);

endinterface

// File: rtl/aes_block_serializer_word_mux.sv
// aes_word_mux: combinational selection of one word out of a block.
// Build option AES_SER_WORD_REVERSE_EN: when defined, index 0 selects the
// most-significant word; otherwise index 0 selects bits [WORD_WIDTH-1:0].
module aes_word_mux #(
  parameter int unsigned BLOCK_WIDTH     = 128,
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic [BLOCK_WIDTH-1:0] blk_i,
  input  logic [IDX_W-1:0]       idx_i,
  output logic [WORD_WIDTH-1:0]  word_o
);

  // Pick the word addressed by idx_i; out-of-range indices give zero.
  always_comb begin
    word_o = '0;
    for (int k = 0; k < int'(WORDS_PER_BLOCK); k++) begin
      if (idx_i == IDX_W'(k)) begin
`ifdef AES_SER_WORD_REVERSE_EN
        word_o = blk_i[BLOCK_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH];
`else
        word_o = blk_i[k*WORD_WIDTH +: WORD_WIDTH];
`endif
      end
    end
  end

endmodule

// File: rtl/aes_block_serializer.sv
// aes_block_serializer: takes one AES result block over valid/ready and
// emits it as WORDS_PER_BLOCK words on an HWPE stream source, with
// zero-bubble chaining of consecutive blocks and per-job progress flags.
// Word order is selected by AES_SER_WORD_REVERSE_EN inside aes_word_mux.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SER_IDLE | no block held; blk_ready_o high, stream valid low
// SER_SEND | block held; word idx presented on d_o until handshaken
module aes_block_serializer
  import aes_package::*;
#(
  parameter int unsigned BLOCK_WIDTH     = AES_BLOCK_WIDTH,
  parameter int unsigned WORD_WIDTH      = AES_WORD_WIDTH,
  parameter int unsigned WORDS_PER_BLOCK = AES_WORDS_PER_BLOCK,
  parameter int unsigned CNT_WIDTH       = AES_SER_CNT_WIDTH,
  localparam int unsigned IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic                   clear_i,
  input  logic [BLOCK_WIDTH-1:0] blk_data_i,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  hwpe_stream_intf_stream.source d_o,
  output logic                   busy_o,
  output logic [IDX_W-1:0]       word_idx_o,
  output logic [CNT_WIDTH-1:0]   blocks_done_o
);

  localparam logic [0:0]       ST_IDLE  = SER_IDLE;
  localparam logic [0:0]       ST_SEND  = SER_SEND;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  logic [0:0]             state_q, state_d;
  logic [BLOCK_WIDTH-1:0] blk_q, blk_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   done_q, done_d;

  logic                  send;
  logic                  word_hs;
  logic                  last_hs;
  logic                  blk_ready;
  logic                  blk_accept;
  logic [WORD_WIDTH-1:0] word;

  // Test mode has no functional effect on this block.
  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  // Handshake decode; a new block may enter on the last-word handshake so
  // consecutive blocks stream without a gap. Clear blocks acceptance.
  always_comb begin
    send       = (state_q == ST_SEND);
    word_hs    = send & d_o.ready;
    last_hs    = word_hs & (idx_q == LAST_IDX);
    blk_ready  = ~clear_i & (~send | last_hs);
    blk_accept = blk_valid_i & blk_ready;
  end

  // Next-state logic; the block register only changes on acceptance, so
  // the presented word is stable while the sink stalls.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    done_d  = done_q;
    if (clear_i) begin
      state_d = ST_IDLE;
      blk_d   = '0;
      idx_d   = '0;
      done_d  = '0;
    end else begin
      if (word_hs) begin
        idx_d = idx_q + IDX_W'(1);
      end
      if (last_hs) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        done_d  = done_q + CNT_WIDTH'(1);
      end
      if (blk_accept) begin
        state_d = ST_SEND;
        blk_d   = blk_data_i;
        idx_d   = '0;
      end
    end
  end

  // State, block register, word index and completed-block counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      idx_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  aes_word_mux #(
    .BLOCK_WIDTH     (BLOCK_WIDTH),
    .WORD_WIDTH      (WORD_WIDTH),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .IDX_W           (IDX_W)
  ) u_word_mux (
    .blk_i  (blk_q),
    .idx_i  (idx_q),
    .word_o (word)
  );

  assign d_o.valid     = send;
  assign d_o.data      = word;
  assign d_o.strb      = '1;
  assign blk_ready_o   = blk_ready;
  assign busy_o        = send;
  assign word_idx_o    = idx_q;
  assign blocks_done_o = done_q;

endmodule
